// File: rtl/edge_detect_stream_pkg.sv
// Shared encodings for the streaming 3x3 Laplacian edge detector.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_CLAMP  = 2'd0,
        MODE_ABS    = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } state_e;

    // 8*C needs 3 extra bits, sign and subtraction headroom take the rest.
    localparam int KERN_GROWTH = 5;

    function automatic int kern_w(input int pix_w);
        return pix_w + KERN_GROWTH;
    endfunction

endpackage

// File: rtl/edge_detect_stream_line_buffer.sv
// Two-line delay of one channel, addressed by input column; read-before-write.
module line_buffer #(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             i_wr,
    input  logic [CW-1:0]    i_col,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_d1,
    output logic [PIX_W-1:0] o_d2
);

    logic [PIX_W-1:0] r_l1 [IMG_W];
    logic [PIX_W-1:0] r_l2 [IMG_W];

    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_l1[i_col] <= i_din;
            r_l2[i_col] <= r_l1[i_col];
        end
    end

    assign o_d1 = r_l1[i_col];
    assign o_d2 = r_l2[i_col];

endmodule

// File: rtl/edge_detect_stream.sv
// Streaming 3x3 Laplacian on one colour channel with clamp/abs/threshold/bypass modes.
module edge_detect_stream
    import edge_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 8,
    parameter int CH_SEL = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3*PIX_W-1:0] in_pix,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [PIX_W-1:0]   thresh,
    output logic [3*PIX_W-1:0] out_pix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eol
);

    localparam int KW = kern_w(PIX_W);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    state_e               r_state;
    mode_e                r_mode;
    logic [PIX_W-1:0]     r_thresh;
    logic [CW-1:0]        r_icol, r_ocol;
    logic [RW-1:0]        r_irow, r_orow;
    logic                 r_rdy_en, r_last_loaded;
    logic [3*PIX_W-1:0]   r_out_pix;
    logic                 r_out_valid, r_out_sof, r_out_eol;
    logic [1:0][2:0][PIX_W-1:0] r_win;   // [col][row], row 0 is the oldest line
    logic [2:0][2:0][PIX_W-1:0] w_win;
    logic [PIX_W-1:0]     w_cur, w_d1, w_d2, w_res;
    logic                 w_slot, w_acc, w_fstep, w_step, w_prod, w_border, w_last_in, w_last_out;
    logic signed [KW-1:0] w_lap, w_abs;
    logic                 w_unused;

    assign w_cur      = in_pix[CH_SEL*PIX_W +: PIX_W];
    assign w_unused   = ^in_pix;
    assign w_slot     = !r_out_valid || out_ready;
    assign in_ready   = r_rdy_en && (r_state != ST_FLUSH) && w_slot;
    assign w_acc      = in_valid && in_ready;
    assign w_fstep    = (r_state == ST_FLUSH) && w_slot && !r_last_loaded;
    assign w_step     = w_acc || w_fstep;
    assign w_last_in  = (r_irow == ROW_LAST) && (r_icol == COL_LAST);
    assign w_last_out = (r_orow == ROW_LAST) && (r_ocol == COL_LAST);
    // Output k leaves when input k+IMG_W+1 arrives; flush steps drain the last IMG_W+1.
    assign w_prod     = w_fstep || (w_acc && (r_state == ST_RUN ||
                        (r_state == ST_FILL && r_irow == RW'(1) && r_icol == CW'(1))));
    assign w_border   = (r_orow == '0) || (r_orow == ROW_LAST) || (r_ocol == '0) || (r_ocol == COL_LAST);

    line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W), .CW(CW)) u_lb (
        .clk   (clk),
        .i_wr  (w_acc),
        .i_col (r_icol),
        .i_din (w_cur),
        .o_d1  (w_d1),
        .o_d2  (w_d2)
    );

    always_comb begin
        w_win[0] = r_win[0];
        w_win[1] = r_win[1];
        w_win[2] = {w_cur, w_d1, w_d2};
        w_lap = $signed({2'b00, w_win[1][1], 3'b000});
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                if (!(c == 1 && r == 1))
                    w_lap = w_lap - $signed({5'b00000, w_win[c][r]});
        w_abs = (w_lap < 0) ? -w_lap : w_lap;
    end

    always_comb begin
        w_res = '0;
        if (r_mode == MODE_BYPASS)
            w_res = w_win[1][1];
        else if (!w_border) begin
            case (r_mode)
                MODE_CLAMP:  w_res = (w_lap < 0) ? '0 :
                                     (w_lap > $signed({5'b00000, PIX_MAX})) ? PIX_MAX : w_lap[PIX_W-1:0];
                MODE_ABS:    w_res = (w_abs > $signed({5'b00000, PIX_MAX})) ? PIX_MAX : w_abs[PIX_W-1:0];
                MODE_THRESH: w_res = (w_abs >= $signed({5'b00000, r_thresh})) ? PIX_MAX : '0;
                default:     w_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_CLAMP;
            r_thresh      <= '0;
            r_icol        <= '0;
            r_irow        <= '0;
            r_ocol        <= '0;
            r_orow        <= '0;
            r_rdy_en      <= 1'b0;
            r_last_loaded <= 1'b0;
            r_out_pix     <= '0;
            r_out_valid   <= 1'b0;
            r_out_sof     <= 1'b0;
            r_out_eol     <= 1'b0;
            r_win         <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            if (w_step) begin
                r_win  <= w_win[2:1];
                r_icol <= (r_icol == COL_LAST) ? '0 : r_icol + CW'(1);
                if (r_icol == COL_LAST)
                    r_irow <= (r_irow == ROW_LAST) ? '0 : r_irow + RW'(1);
            end
            if (w_prod) begin
                r_out_pix   <= {3{w_res}};
                r_out_valid <= 1'b1;
                r_out_sof   <= (r_orow == '0) && (r_ocol == '0);
                r_out_eol   <= (r_ocol == COL_LAST);
                r_ocol      <= (r_ocol == COL_LAST) ? '0 : r_ocol + CW'(1);
                if (r_ocol == COL_LAST)
                    r_orow <= (r_orow == ROW_LAST) ? '0 : r_orow + RW'(1);
                if (w_last_out)
                    r_last_loaded <= 1'b1;
            end
            case (r_state)
                ST_IDLE: if (w_acc) begin
                    r_state  <= ST_FILL;
                    r_mode   <= mode_e'(mode);
                    r_thresh <= thresh;
                end
                ST_FILL: if (w_acc && r_irow == RW'(1) && r_icol == CW'(1))
                    r_state <= ST_RUN;
                ST_RUN: if (w_acc && w_last_in)
                    r_state <= ST_FLUSH;
                ST_FLUSH: if (r_last_loaded && r_out_valid && out_ready) begin
                    r_state       <= ST_IDLE;
                    r_last_loaded <= 1'b0;
                    r_icol        <= '0;
                    r_irow        <= '0;
                    r_ocol        <= '0;
                    r_orow        <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_pix   = r_out_pix;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_edge_detect_stream.sv
// Randomized bench for edge_detect_stream against a per-pixel Laplacian model.
module tb_edge_detect_stream;

    localparam int W = 8, H = 8, PW = 8, CH = 1, N = W * H;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [3*PW-1:0] in_pix = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      mode = 2'd0;
    logic [PW-1:0]   thresh = '0;
    logic [3*PW-1:0] out_pix;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_sof, out_eol;

    typedef struct packed {
        logic [23:0] pix;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] img[N];
    logic [23:0] cap[N];
    int          n_chk = 0, n_fail = 0, in_total = 0, out_total = 0;
    bit          rnd_rdy = 0, rnd_gap = 0;
    bit          prev_hold = 0;
    logic [23:0] prev_pix = '0;

    edge_detect_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .CH_SEL(CH)) dut (
        .clk(clk), .reset_n(reset_n), .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .thresh(thresh), .out_pix(out_pix), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int chan(input int idx);
        logic [23:0] p;
        p = img[idx];
        return int'(p[CH*PW +: PW]);
    endfunction

    function automatic int model_pix(input int idx, input int m, input int th);
        int r, c, lap, a;
        r = idx / W;
        c = idx % W;
        if (m == 3) return chan(idx);
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        lap = 8 * chan(idx);
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) lap -= chan((r+dr)*W + c + dc);
        a = (lap < 0) ? -lap : lap;
        case (m)
            0:       return (lap < 0) ? 0 : (lap > 255 ? 255 : lap);
            1:       return (a > 255) ? 255 : a;
            default: return (a >= th) ? 255 : 0;
        endcase
    endfunction

    task automatic build_img(input int kind);
        for (int i = 0; i < N; i++) begin
            logic [7:0] g;
            case (kind)
                0:       g = 8'd100;
                1:       g = (i == 3*W+3) ? 8'd255 : 8'd0;
                default: g = 8'($urandom);
            endcase
            img[i] = {8'($urandom), g, 8'($urandom)};
        end
    endtask

    task automatic run_frame(input int m, input int th, input int switch_mode, input int stop_after);
        int b;
        for (int i = 0; i < N; i++) begin
            logic [7:0] v;
            v = 8'(model_pix(i, m, th));
            exp_q.push_back('{pix: {3{v}}, sof: (i == 0), eol: (i % W == W-1)});
        end
        mode = 2'(m);
        thresh = 8'(th);
        for (int i = 0; i < N; i++) begin
            if (i == stop_after) return;
            if (switch_mode >= 0 && i == 20) mode = 2'(switch_mode);
            if (rnd_gap) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            in_pix = img[i];
            in_valid = 1'b1;
            b = 0;
            do begin
                @(negedge clk);
                b++;
            end while (!in_ready && b < 2000);
            if (!in_ready) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() > 0 && b < 3000) begin
            @(posedge clk);
            b++;
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_hold) chk("hold_stable", {8'd0, out_pix}, {8'd0, prev_pix});
            prev_hold = out_valid && !out_ready;
            prev_pix = out_pix;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", 32'(out_total), 32'(in_total));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("pix[%0d]", out_total % N), {8'd0, out_pix}, {8'd0, e.pix});
                    chk("sof", 32'(out_sof), 32'(e.sof));
                    chk("eol", 32'(out_eol), 32'(e.eol));
                end
                cap[out_total % N] = out_pix;
                out_total++;
            end
            if (in_total > 0 && in_total % N == 0 && out_total < in_total)
                chk("in_ready_flush", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) in_total++;
        end
    end

    initial begin
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // uniform field: Laplacian is zero everywhere
        build_img(0);
        run_frame(0, 0, -1, -1);
        drain();
        chk("frame_count", 32'(out_total), 32'd64);
        chk("uniform_interior", {8'd0, cap[9]}, 32'd0);

        // single bright pixel at (3,3)
        build_img(1);
        chk("model_centre", 32'(model_pix(27, 0, 0)), 32'd255);
        chk("model_nbr_abs", 32'(model_pix(28, 1, 0)), 32'd255);
        run_frame(0, 0, -1, -1);
        drain();
        chk("m0_centre", {8'd0, cap[27]}, 32'h00FFFFFF);
        chk("m0_nbr", {8'd0, cap[28]}, 32'd0);
        run_frame(1, 0, -1, -1);
        drain();
        chk("m1_nbr", {8'd0, cap[36]}, 32'h00FFFFFF);
        chk("m1_far", {8'd0, cap[45]}, 32'd0);
        run_frame(2, 200, -1, -1);
        drain();
        chk("m2_nbr", {8'd0, cap[18]}, 32'h00FFFFFF);
        chk("m2_far", {8'd0, cap[13]}, 32'd0);
        run_frame(2, 255, -1, -1);
        drain();
        chk("m2_thresh_eq", {8'd0, cap[20]}, 32'h00FFFFFF);

        // random images with backpressure and input gaps
        rnd_rdy = 1;
        rnd_gap = 1;
        for (int f = 0; f < 3; f++) begin
            build_img(2);
            run_frame(f, $urandom_range(0, 255), -1, -1);
            drain();
        end

        // mode switch mid-frame takes effect only on the next frame
        build_img(2);
        run_frame(0, 0, 3, -1);
        drain();
        build_img(2);
        run_frame(3, 0, -1, -1);
        drain();
        chk("bypass_corner", {8'd0, cap[0]}, {8'd0, {3{img[0][CH*PW +: PW]}}});

        // reset in the middle of a frame
        build_img(2);
        run_frame(1, 0, -1, 20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_pix", {8'd0, out_pix}, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_sof", 32'(out_sof), 32'd0);
        exp_q.delete();
        in_total = 0;
        out_total = 0;
        prev_hold = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        build_img(2);
        run_frame(1, 0, -1, -1);
        drain();
        chk("post_rst_count", 32'(out_total), 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_detect_stream.md
EDGE_DETECT_STREAM -- requirements
Module: edge_detect_stream

Interface
REQ-001 Parameter IMG_W, 640, active pixels per line (>=3).
REQ-002 Parameter IMG_H, 480, lines per frame (>=3).
REQ-003 Parameter PIX_W, 8, bits per colour channel.
REQ-004 Parameter CH_SEL, 1, source channel for the kernel: 0 blue [PIX_W-1:0], 1 green, 2 red.
REQ-005 Port clk  in  1  single clock; all logic rising-edge.
REQ-006 Port reset_n  in  1  asynchronous active-low reset.
REQ-007 Port in_pix  in  3*PIX_W  raster-order RGB input: blue lowest, red highest.
REQ-008 Port in_valid  in  1  in_pix is valid.
REQ-009 Port in_ready  out  1  block accepts in_pix this cycle.
REQ-010 Port mode  in  2  0 clamp, 1 absolute, 2 threshold, 3 bypass; sampled at the start of each frame.
REQ-011 Port thresh  in  PIX_W  threshold for mode 2; sampled with mode.
REQ-012 Port out_pix  out  3*PIX_W  result, same value replicated on all three channels.
REQ-013 Port out_valid  out  1  out_pix valid.
REQ-014 Port out_ready  in  1  downstream accepts out_pix.
REQ-015 Port out_sof  out  1  high with the first output pixel of a frame.
REQ-016 Port out_eol  out  1  high with the last output pixel of each line.

Function
REQ-017 Transfer occurs on valid&&ready for both ports; out_pix/out_valid SHALL hold stable while out_valid&&!out_ready.
REQ-018 The kernel SHALL be the 3x3 Laplacian: 8*C minus the sum of its 8 neighbours, computed signed at PIX_W+5 bits with no intermediate truncation.
REQ-019 Mode 0 SHALL clamp the result to [0, 2^PIX_W-1]; mode 1 SHALL output |result| clamped to 2^PIX_W-1; mode 2 SHALL output all-ones if |result|>=thresh, else 0; mode 3 SHALL output the selected channel of C.
REQ-020 Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) SHALL output 0 in modes 0-2 and the channel value in mode 3.
REQ-021 Exactly IMG_W*IMG_H outputs per frame, in input raster order.
REQ-022 Output for pixel (r,c) SHALL become eligible one cycle after input pixel (r+1,c+1) is accepted, or during flush for the last line.
REQ-023 FSM states: IDLE (no frame pixel yet) -> FILL on first accept; FILL -> RUN after IMG_W+2 accepts; RUN -> FLUSH after the IMG_W*IMG_H-th accept; FLUSH -> IDLE after the last output transfers.
REQ-024 in_ready SHALL be 0 in FLUSH; otherwise in_ready = !out_valid || out_ready (single-entry output register).
REQ-025 Input and output column/row counters SHALL wrap at IMG_W-1/IMG_H-1 independently; out_eol asserts when output column = IMG_W-1.
REQ-026 mode/thresh changes mid-frame SHALL have no effect until the next IDLE->FILL transition.
REQ-027 No input accepted for any number of cycles SHALL neither lose nor duplicate pixels.

Reset
REQ-028 reset_n low SHALL asynchronously force: FSM IDLE, all counters 0, out_valid 0, out_pix 0, out_sof 0, out_eol 0, in_ready 0.
REQ-029 Line-buffer contents need not be cleared; a frame in progress at reset SHALL be discarded and the next accepted pixel treated as (0,0).
REQ-030 in_ready SHALL rise on the first clk edge after reset_n deasserts.

Structure
REQ-031 Package edge_pkg SHALL hold the mode encodings, FSM state enumeration and kernel width constant (PIX_W+5).
REQ-032 One sub-module line_buffer SHALL be used (parameters IMG_W, PIX_W; two-line delay of the selected channel, one read/write per accepted pixel); two instances are not required.

Verification
REQ-033 IMG_W=IMG_H=8, uniform 100, mode 0 -> 64 outputs, all 0, out_sof on first, out_eol on every 8th.
REQ-034 Zero field with single pixel 255 at (3,3), mode 0 -> (3,3)=255, its 8 neighbours 0; mode 1 -> neighbours 255.
REQ-035 Same image, mode 2, thresh 200 -> (3,3) and its 8 neighbours 255, all others 0.
REQ-036 out_ready toggled randomly 50% -> output stream identical to the out_ready=1 run; no in_ready during FLUSH.
REQ-037 reset_n pulsed low at pixel 20 of a frame, then a fresh frame -> outputs cleared immediately; the following frame is correct and complete.
REQ-038 Mode changed from 0 to 3 mid-frame -> current frame stays in mode 0; next frame is bypass.
